serializer_hs: RTL and testbench
================================

# serializer_hs

Parallel-to-serial converter with a one-word holding buffer and downstream backpressure. It is the transmit counterpart of the team's `deserializer` block. It takes a DATA_W-bit word plus a valid-bit count and shifts the valid bits out MSB-first, one bit per accepted cycle. The bit stream it produces is the `data_i`/`data_val_i` stream that `deserializer` consumes. The holding buffer allows back-to-back words with no idle cycle between them.

## Interface
- DATA_W, 16, parallel word width (≥4)
- MOD_W, $clog2(DATA_W), width of the bit-count field
- clk_i  in  1  clock; all state updates on rising edge
- arst_n_i  in  1  asynchronous, active-low reset
- data_i  in  DATA_W  parallel word; valid bits are the MSB-aligned top bits
- data_mod_i  in  MOD_W  number of valid bits; 0 means DATA_W
- data_val_i  in  1  word offered this cycle
- ser_ready_i  in  1  downstream accepts the current bit this cycle
- ser_data_o  out  1  current serial bit
- ser_data_val_o  out  1  ser_data_o is valid
- busy_o  out  1  holding buffer full; offered words are ignored
- word_done_o  out  1  one-cycle pulse after the last bit of a word transfers

## Operation
- Storage:
  - Active shift register `shreg` with remaining-bit counter `cnt` (MOD_W+1 bits).
  - Holding register `hold_data`/`hold_cnt`/`hold_full`.
- States:
  - IDLE: `cnt`==0, ser_data_val_o=0.
  - SHIFT: `cnt`>0, ser_data_val_o=1.
- Effective length: len = (data_mod_i==0) ? DATA_W : data_mod_i.
- Words with len 1 or 2 are dropped silently: no storage, no busy_o change, no word_done_o.
- Accept condition: data_val_i && !busy_o && len≥3.
- On accept, the word goes to the first applicable destination:
  - Into `shreg` if IDLE, or if the last bit of the active word transfers on this same edge and the holding buffer is empty.
  - Otherwise into the holding buffer (hold_full←1).
- A bit transfers on an edge with ser_data_val_o && ser_ready_i. On a transfer:
  - `shreg` shifts left by 1.
  - `cnt` decrements.
- ser_data_o = shreg[DATA_W-1] while in SHIFT; it is 0 in IDLE.
- Last-bit transfer (`cnt`==1):
  - If hold_full: hold→shreg and hold_full←0, on the same edge, with no bubble.
  - Else if an accept occurs on that edge: the new word goes directly to `shreg`.
  - Else: go to IDLE.
- ser_ready_i low: `shreg`, `cnt` and outputs all hold. The bit is not repeated or lost.
- Bits below len in a word are never emitted.
- busy_o = hold_full. It is a registered output, so it has no combinational dependence on data_val_i or ser_ready_i.
- word_done_o is registered. It is 1 for exactly the cycle after each edge on which a word's last bit transfers.

## Timing
- Reset (arst_n_i=0, asynchronous):
  - ser_data_o=0, ser_data_val_o=0, busy_o=0, word_done_o=0.
  - `cnt`=0, hold_full=0.
  - A word in flight is aborted; no word_done_o is generated for it.
- Reset release: the block is in IDLE. A word may be accepted on the first rising edge after deassertion.
- Latency, word accepted at edge N while IDLE:
  - First bit valid in the cycle after N.
  - With ser_ready_i held high, the final bit is valid in cycle N+len.
  - word_done_o is high in cycle N+len+1.
- Throughput: with ser_ready_i high and a new word offered while busy_o=0, ser_data_val_o stays continuously high across word boundaries.
- busy_o behaviour:
  - Rises the cycle after a word lands in hold.
  - Falls the cycle after hold moves to `shreg`.
  - A word offered during that falling edge is ignored because busy_o is still 1.
- All outputs change only on clk_i edges, except on async reset assertion.

## Test plan
- Reset: assert arst_n_i mid-simulation with no clock -> all outputs read 0 immediately. After release, busy_o=0 and ser_data_val_o=0.
- Full word: data_i=16'hB5A3, mod=0, ser_ready_i=1 -> 16 consecutive valid bits 1011_0101_1010_0011. Then one word_done_o pulse, and ser_data_val_o=0.
- Partial and invalid lengths:
  - data_i=16'hA800, mod=5 -> bits 10101, with 5 valid cycles.
  - mod=1 and mod=2 -> nothing emitted, busy_o stays 0.
  - mod=3, data_i=16'hE000 -> bits 111.
- Back-to-back: offer 16'hFFFF then 16'h0000 on consecutive cycles, both mod=0 -> busy_o high from cycle 2 until the handoff. Output is 32 contiguous valid cycles (16 ones, then 16 zeros), with two word_done_o pulses 16 cycles apart. A third word offered while busy_o=1 is never emitted.
- Backpressure: 16'hC3C3, ser_ready_i driven by a pseudo-random pattern at ~50% -> the collected bits equal 1100_0011_1100_0011. Each bit is held stable while ser_ready_i=0.
- Reset mid-word: assert arst_n_i after 7 bits of a 16-bit word with hold full -> no word_done_o. Post-reset word 16'h8001 is emitted cleanly.

Source files
------------

// File: rtl/serializer_hs.sv
// serializer_hs: parallel-to-serial converter with a one-word holding buffer.
// Words carry an MSB-aligned payload whose bit count is given by data_mod_i
// (0 means a full DATA_W-bit word). The payload is shifted out MSB-first, one
// bit per cycle in which the downstream asserts ser_ready_i.
//
// Handshake: a serial bit moves on every rising edge where ser_data_val_o and
// ser_ready_i are both high. While ser_ready_i is low the bit, the valid flag
// and all internal state hold. Upstream offers a word with data_val_i. The word
// is taken on an edge where busy_o is low and its length is at least 3. There
// is no per-word acknowledge, so the offering side must watch busy_o.
module serializer_hs #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              arst_n_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   input  logic              ser_ready_i,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o,
   output logic              word_done_o,
   output logic              dbg_state_o
);

   localparam int CNT_W = MOD_W + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   hold_data_q, hold_data_d;
   logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
   logic                hold_full_q, hold_full_d;
   logic                done_q, done_d;

   logic [CNT_W-1:0]    len;
   logic                accept;
   logic                xfer;
   logic                last_xfer;

   // Decode the offered word length and the per-edge events.
   always_comb begin
      len       = (data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, data_mod_i};
      // Words of one or two bits are not worth framing and are dropped.
      accept    = data_val_i && !hold_full_q && (len >= CNT_W'(3));
      xfer      = (state_q == SHIFT) && ser_ready_i;
      last_xfer = xfer && (cnt_q == CNT_W'(1));
   end

   // Next-state logic: shift, reload from hold or input, and park in hold.
   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      hold_data_d = hold_data_q;
      hold_cnt_d  = hold_cnt_q;
      hold_full_d = hold_full_q;
      done_d      = last_xfer;
      state_d     = state_q;

      if (xfer) begin
         shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
         cnt_d   = cnt_q - CNT_W'(1);
      end

      // Handoff on the last bit: the held word wins, otherwise a word offered
      // on this same edge goes straight into the shifter (no bubble either way).
      if (last_xfer && hold_full_q) begin
         shreg_d     = hold_data_q;
         cnt_d       = hold_cnt_q;
         hold_full_d = 1'b0;
      end

      if (accept) begin
         if ((state_q == IDLE) || last_xfer) begin
            shreg_d = data_i;
            cnt_d   = len;
         end else begin
            hold_data_d = data_i;
            hold_cnt_d  = len;
            hold_full_d = 1'b1;
         end
      end

      state_d = (cnt_d != '0) ? SHIFT : IDLE;
   end

   // State registers; reset aborts any word in flight without a done pulse.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         hold_data_q <= '0;
         hold_cnt_q  <= '0;
         hold_full_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         hold_data_q <= hold_data_d;
         hold_cnt_q  <= hold_cnt_d;
         hold_full_q <= hold_full_d;
         done_q      <= done_d;
      end
   end

   assign ser_data_val_o = (state_q == SHIFT);
   assign ser_data_o     = (state_q == SHIFT) && shreg_q[DATA_W-1];
   assign busy_o         = hold_full_q;
   assign word_done_o    = done_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_serializer_hs.sv
// Directed testbench for serializer_hs (DATA_W = 16).
module tb_serializer_hs;

   logic        clk;
   logic        arst_n;
   logic [15:0] data;
   logic [3:0]  data_mod;
   logic        data_val;
   logic        ser_ready;
   logic        ser_data;
   logic        ser_data_val;
   logic        busy;
   logic        word_done;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;

   logic bit_q[$];
   int   done_cnt = 0;

   serializer_hs #(.DATA_W(16)) dut (
      .clk_i          (clk),
      .arst_n_i       (arst_n),
      .data_i         (data),
      .data_mod_i     (data_mod),
      .data_val_i     (data_val),
      .ser_ready_i    (ser_ready),
      .ser_data_o     (ser_data),
      .ser_data_val_o (ser_data_val),
      .busy_o         (busy),
      .word_done_o    (word_done),
      .dbg_state_o    (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every transferred bit and every done pulse.
   always @(posedge clk) begin
      if (ser_data_val && ser_ready) bit_q.push_back(ser_data);
      if (word_done) done_cnt++;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      bit_q.delete();
      done_cnt = 0;
   endtask

   task automatic pop_bits(output logic [31:0] v, output int n);
      v = '0;
      n = 0;
      while (bit_q.size() > 0) begin
         v = {v[30:0], bit_q.pop_front()};
         n++;
      end
   endtask

   task automatic test_reset();
      arst_n = 1'b0; data = '0; data_mod = '0; data_val = 1'b0; ser_ready = 1'b1;
      #1;
      checks++; if (ser_data !== 1'b0) begin errors++; $display("FAIL rst_data got %b exp 0", ser_data); end
      checks++; if (ser_data_val !== 1'b0) begin errors++; $display("FAIL rst_val got %b exp 0", ser_data_val); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", word_done); end
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_busy got %b exp 0", busy); end
      checks++; if (ser_data_val !== 1'b0) begin errors++; $display("FAIL rel_val got %b exp 0", ser_data_val); end
   endtask

   task automatic test_full_word();
      logic [31:0] v;
      int n;
      @(negedge clk);
      clear_mon();
      data = 16'hB5A3; data_mod = 4'd0; data_val = 1'b1; ser_ready = 1'b1;
      @(negedge clk);
      data_val = 1'b0;
      checks++; if (ser_data_val !== 1'b1) begin errors++; $display("FAIL full_first_val got %b exp 1", ser_data_val); end
      checks++; if (ser_data !== 1'b1) begin errors++; $display("FAIL full_first_bit got %b exp 1", ser_data); end
      repeat (15) @(negedge clk);
      checks++; if (ser_data_val !== 1'b1) begin errors++; $display("FAIL full_last_val got %b exp 1", ser_data_val); end
      checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL full_early_done got %b exp 0", word_done); end
      @(negedge clk);
      checks++; if (word_done !== 1'b1) begin errors++; $display("FAIL full_done got %b exp 1", word_done); end
      checks++; if (ser_data_val !== 1'b0) begin errors++; $display("FAIL full_end_val got %b exp 0", ser_data_val); end
      @(negedge clk);
      checks++; if (word_done !== 1'b0) begin errors++; $display("FAIL full_done_width got %b exp 0", word_done); end
      pop_bits(v, n);
      checks++; if (v[15:0] !== 16'hB5A3) begin errors++; $display("FAIL full_bits got %h exp b5a3", v[15:0]); end
      checks++; if (n !== 16) begin errors++; $display("FAIL full_count got %0d exp 16", n); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_cnt got %0d exp 1", done_cnt); end
   endtask

   task automatic test_partial();
      logic [31:0] v;
      int n;
      // 5-bit word
      @(negedge clk);
      clear_mon();
      data = 16'hA800; data_mod = 4'd5; data_val = 1'b1;
      @(negedge clk);
      data_val = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (ser_data_val !== 1'b1) begin errors++; $display("FAIL p5_last_val got %b exp 1", ser_data_val); end
      @(negedge clk);
      checks++; if (ser_data_val !== 1'b0 || word_done !== 1'b1) begin
         errors++; $display("FAIL p5_end got val=%b done=%b exp val=0 done=1", ser_data_val, word_done); end
      repeat (2) @(negedge clk);
      pop_bits(v, n);
      checks++; if (v[4:0] !== 5'b10101 || n !== 5) begin
         errors++; $display("FAIL p5_bits got %b n=%0d exp 10101 n=5", v[4:0], n); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL p5_done_cnt got %0d exp 1", done_cnt); end
      // lengths 1 and 2 are dropped
      clear_mon();
      for (int m = 1; m <= 2; m++) begin
         data = 16'hFFFF; data_mod = 4'(m); data_val = 1'b1;
         @(negedge clk);
         data_val = 1'b0;
         checks++; if (busy !== 1'b0 || ser_data_val !== 1'b0) begin
            errors++; $display("FAIL drop_len%0d got busy=%b val=%b exp 0 0", m, busy, ser_data_val); end
      end
      repeat (3) @(negedge clk);
      checks++; if (bit_q.size() !== 0 || done_cnt !== 0) begin
         errors++; $display("FAIL drop_emit got bits=%0d done=%0d exp 0 0", bit_q.size(), done_cnt); end
      // 3-bit word, the shortest accepted
      clear_mon();
      data = 16'hE000; data_mod = 4'd3; data_val = 1'b1;
      @(negedge clk);
      data_val = 1'b0;
      repeat (6) @(negedge clk);
      pop_bits(v, n);
      checks++; if (v[2:0] !== 3'b111 || n !== 3) begin
         errors++; $display("FAIL p3_bits got %b n=%0d exp 111 n=3", v[2:0], n); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL p3_done_cnt got %0d exp 1", done_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      int n;
      int gaps;
      gaps = 0;
      @(negedge clk);
      clear_mon();
      data = 16'hFFFF; data_mod = 4'd0; data_val = 1'b1; ser_ready = 1'b1;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k <= 32 && ser_data_val !== 1'b1) gaps++;
         if (k == 1) begin
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_c1 got %b exp 0", busy); end
            data = 16'h0000;
         end
         if (k == 2) begin
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_c2 got %b exp 1", busy); end
         end
         if (k >= 2 && k <= 16) data = 16'hAAAA;
         if (k == 16) begin
            checks++; if (busy !== 1'b1 || word_done !== 1'b0) begin
               errors++; $display("FAIL b2b_c16 got busy=%b done=%b exp 1 0", busy, word_done); end
         end
         if (k == 17) begin
            data_val = 1'b0;
            checks++; if (busy !== 1'b0 || word_done !== 1'b1) begin
               errors++; $display("FAIL b2b_c17 got busy=%b done=%b exp 0 1", busy, word_done); end
            checks++; if (ser_data !== 1'b0) begin errors++; $display("FAIL b2b_second_first got %b exp 0", ser_data); end
         end
         if (k == 33) begin
            checks++; if (word_done !== 1'b1 || ser_data_val !== 1'b0) begin
               errors++; $display("FAIL b2b_c33 got done=%b val=%b exp 1 0", word_done, ser_data_val); end
         end
      end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_contig got %0d gaps exp 0", gaps); end
      pop_bits(v, n);
      checks++; if (v !== 32'hFFFF0000 || n !== 32) begin
         errors++; $display("FAIL b2b_bits got %h n=%0d exp ffff0000 n=32", v, n); end
      checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_cnt got %0d exp 2", done_cnt); end
   endtask

   task automatic test_backpressure();
      logic [31:0] v;
      int n;
      int unstable;
      bit seen_done;
      logic prev_val, prev_ready, prev_data;
      unstable = 0; seen_done = 1'b0;
      @(negedge clk);
      clear_mon();
      data = 16'hC3C3; data_mod = 4'd0; data_val = 1'b1;
      ser_ready = 1'($urandom_range(0, 1));
      prev_val = 1'b0; prev_ready = 1'b1; prev_data = 1'b0;
      for (int k = 0; k < 300 && !seen_done; k++) begin
         @(negedge clk);
         data_val = 1'b0;
         if (prev_val && !prev_ready && (ser_data_val !== 1'b1 || ser_data !== prev_data)) unstable++;
         if (word_done === 1'b1) seen_done = 1'b1;
         prev_val = ser_data_val;
         prev_data = ser_data;
         ser_ready = 1'($urandom_range(0, 1));
         prev_ready = ser_ready;
      end
      ser_ready = 1'b1;
      checks++; if (!seen_done) begin errors++; $display("FAIL bp_timeout got no done exp done within 300 cycles"); end
      pop_bits(v, n);
      checks++; if (v[15:0] !== 16'hC3C3 || n !== 16) begin
         errors++; $display("FAIL bp_bits got %h n=%0d exp c3c3 n=16", v[15:0], n); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] v;
      int n;
      @(negedge clk);
      clear_mon();
      data = 16'h5555; data_mod = 4'd0; data_val = 1'b1; ser_ready = 1'b1;
      @(negedge clk);
      data = 16'h3333;
      @(negedge clk);
      data_val = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
      repeat (6) @(negedge clk);
      pop_bits(v, n);
      checks++; if (v[6:0] !== 7'b0101010 || n !== 7) begin
         errors++; $display("FAIL mid_prefix got %b n=%0d exp 0101010 n=7", v[6:0], n); end
      clear_mon();
      #2 arst_n = 1'b0;
      #1;
      checks++; if (ser_data_val !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0 || ser_data !== 1'b0) begin
         errors++; $display("FAIL mid_async got val=%b busy=%b done=%b data=%b exp all 0",
                            ser_data_val, busy, word_done, ser_data); end
      repeat (3) @(negedge clk);
      checks++; if (done_cnt !== 0 || bit_q.size() !== 0) begin
         errors++; $display("FAIL mid_abort got done=%0d bits=%0d exp 0 0", done_cnt, bit_q.size()); end
      arst_n = 1'b1;
      data = 16'h8001; data_mod = 4'd0; data_val = 1'b1;
      @(negedge clk);
      data_val = 1'b0;
      checks++; if (ser_data_val !== 1'b1 || ser_data !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL post_first got val=%b data=%b busy=%b exp 1 1 0", ser_data_val, ser_data, busy); end
      repeat (18) @(negedge clk);
      pop_bits(v, n);
      checks++; if (v[15:0] !== 16'h8001 || n !== 16) begin
         errors++; $display("FAIL post_bits got %h n=%0d exp 8001 n=16", v[15:0], n); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL post_done_cnt got %0d exp 1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_partial();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
